// File: rtl/ps_hp_pkg.sv
// Shared types and constants for the pshare table-port scheduler.
package ps_hp_pkg;

    localparam int PS_BHT_ENTERIES_DEF   = 256;
    localparam int PS_INSTR_SIZE_BYTE_DEF = 4;
    localparam int PS_Q_DEPTH_DEF        = 4;
    localparam int PS_STARVE_LIMIT_DEF   = 8;

    function automatic int pc_width(input int instr_size_byte);
        return instr_size_byte * 8;
    endfunction

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    localparam int PS_PCW_DEF = pc_width(PS_INSTR_SIZE_BYTE_DEF);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic [PS_PCW_DEF-1:0] pc;
        logic                  taken;
        logic [PS_PCW_DEF-1:0] offset;
    } upd_entry_t;

    // Why the port went where it did this cycle, highest priority first after INIT.
    typedef enum logic [2:0] {
        GR_IDLE,
        GR_INIT,
        GR_FULL,
        GR_STARVE,
        GR_HAZARD,
        GR_LOOKUP,
        GR_DRAIN
    } grant_e;

endpackage

// File: rtl/ps_hp_upd_fifo.sv
// In-order register FIFO of pending table updates, with a parallel
// index compare of every live entry against the current fetch index.
module ps_hp_upd_fifo
    import ps_hp_pkg::*;
#(
    parameter int  Q_DEPTH = PS_Q_DEPTH_DEF,
    parameter int  IDX_W   = 8,
    parameter type entry_t = upd_entry_t
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic [IDX_W-1:0]         push_idx,
    input  logic                     pop,
    output entry_t                   head_entry,
    output logic [$clog2(Q_DEPTH):0] count,
    input  logic [IDX_W-1:0]         lookup_idx,
    output logic                     hazard
);

    localparam int PTR_W = $clog2(Q_DEPTH);

    entry_t           mem     [Q_DEPTH];
    logic [IDX_W-1:0] idx_mem [Q_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [Q_DEPTH-1:0] match;

    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg]     <= push_entry;
            idx_mem[tail_reg] <= push_idx;
        end
    end

    // A slot is live when its distance from head (mod depth) is below the occupancy.
    genvar gi;
    for (gi = 0; gi < Q_DEPTH; gi++) begin : g_cmp
        logic [PTR_W-1:0] age;
        assign age       = PTR_W'(gi) - head_reg;
        assign match[gi] = ({1'b0, age} < count_reg) && (idx_mem[gi] == lookup_idx);
    end

    assign hazard     = |match;
    assign head_entry = mem[head_reg];
    assign count      = count_reg;

endmodule

// File: rtl/ps_hp_port_sched.sv
// Arbitrates the single pshare table port between the init sweep,
// fetch lookups and queued execute-stage updates.
module ps_hp_port_sched
    import ps_hp_pkg::*;
#(
    parameter int BHT_ENTERIES    = PS_BHT_ENTERIES_DEF,
    parameter int INSTR_SIZE_BYTE = PS_INSTR_SIZE_BYTE_DEF,
    parameter int Q_DEPTH         = PS_Q_DEPTH_DEF,
    parameter int STARVE_LIMIT    = PS_STARVE_LIMIT_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [pc_width(INSTR_SIZE_BYTE)-1:0]  in_fetch_pc,
    input  logic                                  in_fetch_nop,
    input  logic [pc_width(INSTR_SIZE_BYTE)-1:0]  in_exe_pc,
    input  logic                                  in_exe_nop,
    input  logic                                  in_exe_branch_taken,
    input  logic [pc_width(INSTR_SIZE_BYTE)-1:0]  in_exe_branch_offset,
    output logic                                  out_tbl_lookup_en,
    output logic [pc_width(INSTR_SIZE_BYTE)-1:0]  out_tbl_lookup_pc,
    output logic                                  out_tbl_update_en,
    output logic [pc_width(INSTR_SIZE_BYTE)-1:0]  out_tbl_update_pc,
    output logic                                  out_tbl_update_taken,
    output logic [pc_width(INSTR_SIZE_BYTE)-1:0]  out_tbl_update_offset,
    output logic                                  out_tbl_init_en,
    output logic [idx_width(BHT_ENTERIES)-1:0]    out_tbl_init_idx,
    output logic                                  out_fetch_stall,
    output logic                                  out_exe_stall,
    output logic                                  out_init_busy,
    output logic [$clog2(Q_DEPTH):0]              out_q_count
);

    localparam int PCW      = pc_width(INSTR_SIZE_BYTE);
    localparam int IDX_W    = idx_width(BHT_ENTERIES);
    localparam int CNT_W    = $clog2(Q_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
        logic [PCW-1:0] offset;
    } entry_t;

    state_e             state_reg, state_next;
    logic [IDX_W-1:0]   init_idx_reg, init_idx_next;
    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
    grant_e             grant;
    entry_t             push_entry, head_entry;
    logic [CNT_W-1:0]   q_count;
    logic               hazard, fetch_valid, q_full, q_empty, push, pop;

    ps_hp_upd_fifo #(
        .Q_DEPTH (Q_DEPTH),
        .IDX_W   (IDX_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .srst       (rst),
        .push       (push),
        .push_entry (push_entry),
        .push_idx   (in_exe_pc[IDX_W+1:2]),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (q_count),
        .lookup_idx (in_fetch_pc[IDX_W+1:2]),
        .hazard     (hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= INIT;
            init_idx_reg   <= '0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            init_idx_reg   <= init_idx_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign fetch_valid = !in_fetch_nop;
    assign q_full      = (q_count == CNT_W'(Q_DEPTH));
    assign q_empty     = (q_count == '0);

    always_comb begin
        state_next    = state_reg;
        init_idx_next = init_idx_reg;
        grant         = GR_IDLE;
        if (rst) begin
            grant = GR_IDLE;
        end else if (state_reg == INIT) begin
            grant         = GR_INIT;
            init_idx_next = init_idx_reg + 1'b1;
            if (init_idx_reg == IDX_W'(BHT_ENTERIES - 1)) state_next = RUN;
        end else if (q_full) begin
            grant = GR_FULL;
        end else if (starve_cnt_reg == STARVE_W'(STARVE_LIMIT)) begin
            grant = GR_STARVE;
        end else if (fetch_valid && hazard) begin
            grant = GR_HAZARD;
        end else if (fetch_valid) begin
            grant = GR_LOOKUP;
        end else if (!q_empty) begin
            grant = GR_DRAIN;
        end
    end

    assign pop  = (grant == GR_FULL) || (grant == GR_STARVE) ||
                  (grant == GR_HAZARD) || (grant == GR_DRAIN);
    // Push is judged on registered occupancy so a full queue never accepts, even when popping.
    assign push = !rst && (state_reg == RUN) && !in_exe_nop && !q_full;
    assign push_entry = '{pc: in_exe_pc, taken: in_exe_branch_taken, offset: in_exe_branch_offset};

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (q_empty || pop) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    assign out_tbl_lookup_en     = (grant == GR_LOOKUP);
    assign out_tbl_lookup_pc     = in_fetch_pc;
    assign out_tbl_update_en     = pop;
    assign out_tbl_update_pc     = pop ? head_entry.pc : '0;
    assign out_tbl_update_taken  = pop ? head_entry.taken : 1'b0;
    assign out_tbl_update_offset = pop ? head_entry.offset : '0;
    assign out_tbl_init_en       = (grant == GR_INIT);
    assign out_tbl_init_idx      = init_idx_reg;
    assign out_init_busy         = rst || (state_reg == INIT);
    assign out_fetch_stall       = out_init_busy || (fetch_valid && !out_tbl_lookup_en);
    assign out_exe_stall         = out_init_busy || q_full;
    assign out_q_count           = q_count;

endmodule
